// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_arb_pkg;

   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_MAX_BURST = 4;
   localparam int unsigned OH_MAX        = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // OR of the set bit positions; exact for one-hot or all-zero inputs.
   function automatic int unsigned onehot_to_idx(input logic [OH_MAX-1:0] oh);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < OH_MAX; i++) begin
         if (oh[i[4:0]]) r = r | i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_burst_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   logic [NUM_REQ-1:0] req_i;
   logic [NUM_REQ-1:0] gnt_o;
   logic               gnt_vld_o;
   logic [IDX_W-1:0]   gnt_idx_o;
   logic [CNT_W-1:0]   burst_cnt_o;

   modport master (
      output req_i,
      input  gnt_o,
      input  gnt_vld_o,
      input  gnt_idx_o,
      input  burst_cnt_o
   );

   modport slave (
      input  req_i,
      output gnt_o,
      output gnt_vld_o,
      output gnt_idx_o,
      output burst_cnt_o
   );

endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotating-priority picker: first set, non-excluded req bit
// scanning upward from start with wrap.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   input  logic [NUM_REQ-1:0] excl,
   output logic               found,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin
      found  = 1'b0;
      onehot = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         int unsigned      pos;
         logic [IDX_W-1:0] p;
         pos = int'(start) + off;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         p = IDX_W'(pos);
         if (!found && req[p] && !excl[p]) begin
            found     = 1'b1;
            onehot[p] = 1'b1;
         end
      end
   end

   assign idx = IDX_W'(onehot_to_idx(OH_MAX'(onehot)));

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded bursts; grant, index and burst count are
// registered and change one edge after the requests are sampled.
module rr_burst_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic               clk,
   input  logic               reset,
   rr_burst_arbiter_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               vld_q, vld_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   logic [NUM_REQ-1:0] cur_oh;
   logic [NUM_REQ-1:0] others_c;
   logic [IDX_W-1:0]   after_idx_c;
   logic [IDX_W-1:0]   pick_start;
   logic [NUM_REQ-1:0] pick_excl;
   logic               pick_found;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;

   assign cur_oh      = NUM_REQ'(1) << idx_q;
   assign others_c    = bus.req_i & ~cur_oh;
   assign after_idx_c = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   // Idle searches from the pointer; a granted owner hands off starting after itself.
   assign pick_start = (state_q == GRANT) ? after_idx_c : ptr_q;
   assign pick_excl  = (state_q == GRANT) ? cur_oh : '0;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req_i),
      .start  (pick_start),
      .excl   (pick_excl),
      .found  (pick_found),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            vld_d = 1'b0;
            cnt_d = '0;
            if (pick_found) begin
               state_d = GRANT;
               gnt_d   = pick_oh;
               vld_d   = 1'b1;
               idx_d   = pick_idx;
               cnt_d   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (bus.req_i[idx_q] && (cnt_q < CNT_W'(MAX_BURST) || others_c == '0)) begin
               if (cnt_q < CNT_W'(MAX_BURST)) cnt_d = cnt_q + CNT_W'(1);
            end else if (pick_found) begin
               // Release or forced rotation: hand straight to the next waiter.
               gnt_d = pick_oh;
               idx_d = pick_idx;
               cnt_d = CNT_W'(1);
               ptr_d = after_idx_c;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               vld_d   = 1'b0;
               cnt_d   = '0;
               ptr_d   = after_idx_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.gnt_o       = gnt_q;
   assign bus.gnt_vld_o   = vld_q;
   assign bus.gnt_idx_o   = idx_q;
   assign bus.burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random requests against an integer-level model of the arbitration rules.
module tb_rr_burst_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned MB = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   rr_burst_arbiter_if #(.NUM_REQ(N), .MAX_BURST(MB)) bus ();

   rr_burst_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: owner index or none, pointer, burst count, last granted index.
   int         m_ptr, m_g, m_cnt, m_idx;
   bit         m_has;
   logic [N-1:0] last_req;

   int t2_cnt[6]  = '{1, 2, 3, 4, 4, 4};
   int t3_gnt[17] = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4, 8, 8, 8, 8, 1};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit bit_of(input logic [N-1:0] v, input int p);
      logic [N-1:0] sh;
      sh = v >> p;
      return sh[0];
   endfunction

   function automatic int pick_m(input int start, input int excl, input logic [N-1:0] r);
      for (int k = 0; k < int'(N); k++) begin
         int p;
         p = (start + k) % int'(N);
         if (p != excl && bit_of(r, p)) return p;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_ptr = 0; m_g = 0; m_cnt = 0; m_idx = 0; m_has = 0;
      last_req = '0;
   endtask

   task automatic m_step(input logic [N-1:0] r);
      int others;
      if (!m_has) begin
         if (r != '0) begin
            m_g = pick_m(m_ptr, -1, r); m_has = 1; m_cnt = 1; m_idx = m_g;
         end
      end else begin
         others = int'(r) & ~(1 << m_g);
         if (bit_of(r, m_g) && (m_cnt < int'(MB) || others == 0)) begin
            if (m_cnt < int'(MB)) m_cnt++;
         end else if (others != 0) begin
            m_ptr = (m_g + 1) % int'(N);
            m_g = pick_m(m_ptr, m_g, r); m_cnt = 1; m_idx = m_g;
         end else begin
            m_ptr = (m_g + 1) % int'(N);
            m_has = 0; m_cnt = 0;
         end
      end
   endtask

   task automatic compare();
      logic [N-1:0] sh;
      chk("gnt",       int'(bus.gnt_o),       m_has ? (1 << m_g) : 0);
      chk("gnt_vld",   int'(bus.gnt_vld_o),   int'(m_has));
      chk("gnt_idx",   int'(bus.gnt_idx_o),   m_idx);
      chk("burst_cnt", int'(bus.burst_cnt_o), m_cnt);
      chk("onehot0",   int'($onehot0(bus.gnt_o)), 1);
      sh = bus.gnt_o >> bus.gnt_idx_o;
      chk("gnt_at_idx", int'(sh[0]), int'(bus.gnt_vld_o));
      chk("gnt_no_req", int'(bus.gnt_o & ~last_req), 0);
   endtask

   task automatic step(input logic [N-1:0] r);
      bus.req_i = r;
      @(posedge clk);
      m_step(r);
      last_req = r;
      #1;
      compare();
   endtask

   task automatic async_reset();
      reset = 1'b0;
      #1;
      chk("areset_gnt", int'(bus.gnt_o), 0);
      chk("areset_vld", int'(bus.gnt_vld_o), 0);
      chk("areset_cnt", int'(bus.burst_cnt_o), 0);
      chk("areset_idx", int'(bus.gnt_idx_o), 0);
      m_reset();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      m_reset();
      bus.req_i = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", int'(bus.gnt_o), 0);
      chk("rst_vld", int'(bus.gnt_vld_o), 0);
      chk("rst_cnt", int'(bus.burst_cnt_o), 0);
      chk("rst_idx", int'(bus.gnt_idx_o), 0);
      reset = 1'b1;

      for (int k = 0; k < 6; k++) begin
         step(4'b1000);
         chk("single_gnt", int'(bus.gnt_o), 8);
         chk("single_idx", int'(bus.gnt_idx_o), 3);
         chk("single_cnt", int'(bus.burst_cnt_o), t2_cnt[k]);
      end
      step(4'b0000);

      for (int k = 0; k < 17; k++) begin
         step(4'b1111);
         chk("contend_gnt", int'(bus.gnt_o), t3_gnt[k]);
      end
      step(4'b0000);

      step(4'b0110);
      chk("release_first", int'(bus.gnt_o), 2);
      step(4'b0100);
      chk("release_gnt", int'(bus.gnt_o), 4);
      chk("release_cnt", int'(bus.burst_cnt_o), 1);
      step(4'b0000);
      chk("release_idle_gnt", int'(bus.gnt_o), 0);
      chk("release_idle_vld", int'(bus.gnt_vld_o), 0);

      step(4'b0011);
      chk("fair_gnt", int'(bus.gnt_o), 1);
      repeat (5) step(4'b0001);
      chk("late_sat_cnt", int'(bus.burst_cnt_o), 4);
      step(4'b0011);
      chk("late_gnt", int'(bus.gnt_o), 2);
      chk("late_cnt", int'(bus.burst_cnt_o), 1);

      async_reset();
      step(4'b0011);
      chk("post_reset_gnt", int'(bus.gnt_o), 1);

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0) r = last_req;
         else if ($urandom_range(0, 5) == 0) r = '0;
         else r = N'($urandom);
         step(r);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
